// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP48A1 slice as a length-N multiply-accumulate
// engine. Operand beats are accepted over valid/ready and strobe CEA/CEB. A
// per-beat tag travels PIPE_LAT cycles so that CEP and OPMODE reach the
// post-adder in the same cycle as the matching product. P and the carry-in
// register are cleared at job start. The result handshake opens once the last
// accumulation has landed in PREG.
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             SUB,
  output logic             BUSY,
  input  logic             OP_VALID,
  output logic             OP_READY,
  output logic             CEA,
  output logic             CEB,
  output logic             CEM,
  output logic             CEP,
  output logic [7:0]       OPMODE,
  output logic             RSTP,
  output logic             RSTCARRYIN,
  output logic             CECARRYIN,
  output logic             RES_VALID,
  input  logic             RES_READY
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                sub_q, sub_d;
  logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [PIPE_LAT-1:0] tag_first_q, tag_first_d;

  logic accept;
  logic tags_empty;
  logic first_beat;

  assign OP_READY   = (state_q == S_RUN) && (rem_q != '0);
  assign accept     = OP_VALID & OP_READY;
  assign tags_empty = (tag_vld_q == '0);
  // The first beat of a job is the one taken while nothing has been consumed yet.
  assign first_beat = (rem_q == len_q);

  assign BUSY       = (state_q != S_IDLE);
  assign CEA        = accept;
  assign CEB        = accept;
  assign CEM        = BUSY;
  assign CEP        = tag_vld_q[PIPE_LAT-1];
  // Z selects 0 for the first beat so the accumulation restarts from the product.
  assign OPMODE     = CEP ? {sub_q, 3'b000, (tag_first_q[PIPE_LAT-1] ? 2'b00 : 2'b10), 2'b01}
                          : 8'h00;
  assign RSTP       = (state_q == S_CLR);
  assign RSTCARRYIN = (state_q == S_CLR);
  assign CECARRYIN  = 1'b0;
  // Once the tag pipe has emptied in DRAIN, PREG already holds the final sum,
  // so the result is offered in that cycle instead of waiting for RESULT.
  assign RES_VALID  = (state_q == S_RESULT) || ((state_q == S_DRAIN) && tags_empty);

  // Job sequencing: latch the job at START, count beats, wait for the tag pipe to empty.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    sub_d   = sub_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLR;
          len_d   = LEN;
          rem_d   = LEN;
          sub_d   = SUB;
        end
      end
      S_CLR: begin
        state_d = (len_q == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (tags_empty) begin
          state_d = RES_READY ? S_IDLE : S_RESULT;
        end
      end
      S_RESULT: begin
        if (RES_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag shift register: stage 0 takes the current beat, bubbles enter as invalid tags.
  always_comb begin
    tag_vld_d      = tag_vld_q;
    tag_first_d    = tag_first_q;
    tag_vld_d[0]   = accept;
    tag_first_d[0] = accept & first_beat;
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_vld_d[i]   = tag_vld_q[i-1];
      tag_first_d[i] = tag_first_q[i-1];
    end
  end

  // State and tag registers; reset abandons any job in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      sub_q       <= 1'b0;
      tag_vld_q   <= '0;
      tag_first_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      sub_q       <= sub_d;
      tag_vld_q   <= tag_vld_d;
      tag_first_q <= tag_first_d;
    end
  end

endmodule
